cp0_int_ctrl: RTL and testbench

CP0_INT_CTRL -- requirements
Module: cp0_int_ctrl

---
 rtl/cp0_int_ctrl.sv | 156 +++++++++++++++
 tb/tb_cp0_int_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_int_ctrl.sv
// rtl/cp0_int_ctrl.sv - CP0 interrupt controller: edge capture, nested priority arbitration, EPC save
//
// Ports:
//   in_CLK, in_RSTn : clock (rising edge) and asynchronous active-low reset
//   irq_in[3:0]     : raw level interrupt sources, bit 3 highest priority
//   ie, inm[3:0]    : global enable (CP0 reg 0 bit 0) and per-source mask (1 = masked)
//   pc_next[31:0]   : address of the next un-executed instruction, captured as EPC on int_ack
//   int_ack, eret   : CPU accepts the request / return-from-interrupt pulse
//   int_req, int_vec, int_addr : request to the CPU, source number and handler entry address
//   cp0_we, cp0_rW, cp0_W      : single-cycle EPC write into the CP0 register file

module cp0_int_ctrl (
    input  logic        in_CLK,
    input  logic        in_RSTn,
    input  logic [3:0]  irq_in,
    input  logic        ie,
    input  logic [3:0]  inm,
    input  logic [31:0] pc_next,
    input  logic        int_ack,
    input  logic        eret,
    output logic        int_req,
    output logic [1:0]  int_vec,
    output logic [31:0] int_addr,
    output logic        cp0_we,
    output logic [1:0]  cp0_rW,
    output logic [31:0] cp0_W
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_REQ   = 2'd1;
    localparam logic [1:0]  ST_SAVE  = 2'd2;

    localparam logic [31:0] VEC_BASE = 32'h0000_1000;
    localparam logic [1:0]  EPC_IDX  = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [1:0]  vec_q;
    logic [1:0]  vec_nxt;
    logic [31:0] epc;
    logic [31:0] epc_nxt;

    logic [3:0]  irq_prev;
    logic [3:0]  pending;
    logic [3:0]  pending_nxt;
    logic [3:0]  in_service;
    logic [3:0]  in_service_nxt;

    logic [3:0]  rise;
    logic [3:0]  above;
    logic [3:0]  eligible;
    logic [3:0]  ack_set;
    logic [3:0]  top_service;
    logic [1:0]  best_idx;
    logic        any_eligible;

    assign rise = irq_in & ~irq_prev;

    // A source may only preempt if it sits strictly above every source
    // currently in service; with nothing in service every term is 1.
    assign above[0] = ~|in_service;
    assign above[1] = ~|in_service[3:1];
    assign above[2] = ~|in_service[3:2];
    assign above[3] = ~in_service[3];

    assign eligible     = pending & ~inm & {4{ie}} & above;
    assign any_eligible = |eligible;

    // Ascending scan: the last hit is the highest-priority eligible source.
    always_comb begin
        best_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (eligible[i]) begin
                best_idx = 2'(i);
            end
        end
    end

    // One-hot of the highest in-service bit; this is what eret retires.
    always_comb begin
        top_service = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (in_service[i]) begin
                top_service = 4'b0000;
                top_service[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        vec_nxt   = vec_q;
        epc_nxt   = epc;
        ack_set   = 4'b0000;
        case (state)
            ST_IDLE: begin
                if (any_eligible) begin
                    vec_nxt   = best_idx;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                // The vector is frozen while requesting; a newly eligible
                // higher source waits until this one is taken or withdrawn.
                if (int_ack) begin
                    ack_set[vec_q] = 1'b1;
                    epc_nxt        = pc_next;
                    state_nxt      = ST_SAVE;
                end else if (!eligible[vec_q]) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SAVE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // A fresh edge wins over the acknowledge clear so it is not lost.
    assign pending_nxt = (pending & ~ack_set) | rise;

    // eret and int_ack touch different bits (the acked source is above all
    // in-service ones), so both updates can land in the same cycle.
    assign in_service_nxt = (in_service & ~(eret ? top_service : 4'b0000)) | ack_set;

    always_ff @(posedge in_CLK or negedge in_RSTn) begin
        if (!in_RSTn) begin
            state      <= ST_IDLE;
            vec_q      <= 2'd0;
            epc        <= 32'h0000_0000;
            irq_prev   <= 4'b0000;
            pending    <= 4'b0000;
            in_service <= 4'b0000;
        end else begin
            state      <= state_nxt;
            vec_q      <= vec_nxt;
            epc        <= epc_nxt;
            irq_prev   <= irq_in;
            pending    <= pending_nxt;
            in_service <= in_service_nxt;
        end
    end

    // Outputs decode directly from registered state so that reset forces
    // them to their idle values immediately, without waiting for a clock.
    assign int_req  = (state == ST_REQ);
    assign int_vec  = vec_q;
    assign int_addr = VEC_BASE + {22'd0, vec_q, 8'd0};
    assign cp0_we   = (state == ST_SAVE);
    assign cp0_rW   = cp0_we ? EPC_IDX : 2'd0;
    assign cp0_W    = cp0_we ? epc : 32'h0000_0000;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// tb/tb_cp0_int_ctrl.sv - directed bench with reference model for cp0_int_ctrl

module tb_cp0_int_ctrl;

    logic        in_CLK = 1'b0;
    logic        in_RSTn = 1'b0;
    logic [3:0]  irq_in = 4'b0000;
    logic        ie = 1'b0;
    logic [3:0]  inm = 4'b0000;
    logic [31:0] pc_next = 32'h0;
    logic        int_ack = 1'b0;
    logic        eret = 1'b0;
    logic        int_req;
    logic [1:0]  int_vec;
    logic [31:0] int_addr;
    logic        cp0_we;
    logic [1:0]  cp0_rW;
    logic [31:0] cp0_W;

    int checks = 0;
    int errors = 0;

    cp0_int_ctrl dut (
        .in_CLK  (in_CLK),
        .in_RSTn (in_RSTn),
        .irq_in  (irq_in),
        .ie      (ie),
        .inm     (inm),
        .pc_next (pc_next),
        .int_ack (int_ack),
        .eret    (eret),
        .int_req (int_req),
        .int_vec (int_vec),
        .int_addr(int_addr),
        .cp0_we  (cp0_we),
        .cp0_rW  (cp0_rW),
        .cp0_W   (cp0_W)
    );

    always #5 in_CLK = ~in_CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending/in-service as sets of source numbers,
    // "busy" = a request is being presented, "save" = EPC write this cycle.
    logic [3:0]  m_prev, m_pend, m_isv;
    bit          m_busy, m_save;
    int          m_vec;
    logic [31:0] m_epc;

    function automatic int top_of(input logic [3:0] v);
        int t = -1;
        for (int i = 0; i < 4; i++) if (v[i]) t = i;
        return t;
    endfunction

    function automatic bit may_take(input int i, input logic [3:0] pend, input logic [3:0] isv,
                                    input logic [3:0] msk, input logic en);
        return pend[i] && !msk[i] && en && (i > top_of(isv));
    endfunction

    task automatic model_reset();
        m_prev = 4'b0; m_pend = 4'b0; m_isv = 4'b0;
        m_busy = 0; m_save = 0; m_vec = 0; m_epc = 32'h0;
    endtask

    task automatic model_step();
        int old_top = top_of(m_isv);
        int best = -1;
        logic [3:0] npend = m_pend;
        logic [3:0] nisv  = m_isv;
        if (m_save) begin
            m_save = 0;
        end else if (m_busy) begin
            if (int_ack) begin
                nisv[m_vec]  = 1'b1;
                npend[m_vec] = 1'b0;
                m_epc  = pc_next;
                m_save = 1;
                m_busy = 0;
            end else if (!may_take(m_vec, m_pend, m_isv, inm, ie)) begin
                m_busy = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) if (may_take(i, m_pend, m_isv, inm, ie)) best = i;
            if (best >= 0) begin
                m_busy = 1;
                m_vec  = best;
            end
        end
        if (eret && old_top >= 0) nisv[old_top] = 1'b0;
        npend  = npend | (irq_in & ~m_prev);
        m_pend = npend;
        m_isv  = nisv;
        m_prev = irq_in;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge in_CLK or negedge in_RSTn);
            if (!in_RSTn) model_reset();
            else model_step();
        end
    end

    always @(negedge in_CLK) begin
        if (!in_RSTn) begin
            chk("cmp_rst_int_req", {31'b0, int_req}, 32'd0);
            chk("cmp_rst_int_vec", {30'b0, int_vec}, 32'd0);
            chk("cmp_rst_int_addr", int_addr, 32'h0000_1000);
            chk("cmp_rst_cp0_we", {31'b0, cp0_we}, 32'd0);
            chk("cmp_rst_cp0_rW", {30'b0, cp0_rW}, 32'd0);
            chk("cmp_rst_cp0_W", cp0_W, 32'd0);
        end else begin
            chk("cmp_int_req", {31'b0, int_req}, {31'b0, m_busy});
            if (m_busy) begin
                chk("cmp_int_vec", {30'b0, int_vec}, 32'(m_vec));
                chk("cmp_int_addr", int_addr, 32'h0000_1000 + 32'(m_vec) * 32'h100);
            end
            chk("cmp_cp0_we", {31'b0, cp0_we}, {31'b0, m_save});
            chk("cmp_cp0_rW", {30'b0, cp0_rW}, m_save ? 32'd2 : 32'd0);
            chk("cmp_cp0_W", cp0_W, m_save ? m_epc : 32'd0);
        end
    end

    task automatic tick();
        @(posedge in_CLK);
        #1;
    endtask

    task automatic wait_req(input string name, input int exp_vec);
        int n = 0;
        while (!int_req && n < 8) begin
            tick();
            n++;
        end
        chk({name, "_req"}, {31'b0, int_req}, 32'd1);
        chk({name, "_vec"}, {30'b0, int_vec}, 32'(exp_vec));
    endtask

    task automatic ack_cycle(input string name, input logic [31:0] pc, input bit with_eret);
        int_ack = 1'b1;
        pc_next = pc;
        eret    = with_eret;
        tick();
        chk({name, "_we"}, {31'b0, cp0_we}, 32'd1);
        chk({name, "_epc"}, cp0_W, pc);
        int_ack = 1'b0;
        eret    = 1'b0;
        tick();
    endtask

    task automatic do_eret();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("rst_int_req", {31'b0, int_req}, 32'd0);
        chk("rst_int_addr", int_addr, 32'h0000_1000);
        chk("rst_cp0_we", {31'b0, cp0_we}, 32'd0);
        in_RSTn = 1'b1;
        ie = 1'b1;
        tick();

        // single source, exact latency, EPC write
        irq_in = 4'b0010;
        tick();
        chk("s1_lat_n1", {31'b0, int_req}, 32'd0);
        tick();
        chk("s1_lat_n2", {31'b0, int_req}, 32'd1);
        chk("s1_vec", {30'b0, int_vec}, 32'd1);
        chk("s1_addr", int_addr, 32'h0000_1100);
        int_ack = 1'b1;
        pc_next = 32'h0000_0040;
        tick();
        chk("s1_we", {31'b0, cp0_we}, 32'd1);
        chk("s1_rW", {30'b0, cp0_rW}, 32'd2);
        chk("s1_W", cp0_W, 32'h0000_0040);
        chk("s1_req_drop", {31'b0, int_req}, 32'd0);
        int_ack = 1'b0;
        tick();
        chk("s1_we_off", {31'b0, cp0_we}, 32'd0);
        chk("s1_W_off", cp0_W, 32'd0);
        do_eret();
        irq_in = 4'b0000;
        tick();

        // simultaneous sources: priority then lower one after eret
        irq_in = 4'b0101;
        tick();
        tick();
        chk("s2_req", {31'b0, int_req}, 32'd1);
        chk("s2_vec", {30'b0, int_vec}, 32'd2);
        chk("s2_addr", int_addr, 32'h0000_1200);
        ack_cycle("s2_ack", 32'h0000_0080, 1'b0);
        tick();
        tick();
        chk("s2_blocked", {31'b0, int_req}, 32'd0);
        do_eret();
        wait_req("s2_second", 0);
        ack_cycle("s2_ack2", 32'h0000_0084, 1'b0);
        do_eret();
        irq_in = 4'b0000;
        tick();

        // masked source released by clearing the mask
        inm = 4'b0100;
        irq_in = 4'b0100;
        repeat (4) tick();
        chk("s3_masked", {31'b0, int_req}, 32'd0);
        inm = 4'b0000;
        wait_req("s3_unmask", 2);
        ack_cycle("s3_ack", 32'h0000_0088, 1'b0);
        do_eret();
        irq_in = 4'b0000;
        tick();

        // nesting: 3 preempts 1, 0 waits for two erets; EPC overwritten
        irq_in = 4'b0010;
        wait_req("s4_v1", 1);
        ack_cycle("s4_ack1", 32'h0000_00a0, 1'b0);
        irq_in = 4'b1010;
        wait_req("s4_v3", 3);
        chk("s4_addr3", int_addr, 32'h0000_1300);
        ack_cycle("s4_ack3", 32'h0000_00a4, 1'b0);
        irq_in = 4'b1011;
        repeat (4) tick();
        chk("s4_no0_a", {31'b0, int_req}, 32'd0);
        do_eret();
        repeat (3) tick();
        chk("s4_no0_b", {31'b0, int_req}, 32'd0);
        do_eret();
        wait_req("s4_v0", 0);
        ack_cycle("s4_ack0", 32'h0000_00a8, 1'b0);
        do_eret();
        irq_in = 4'b0000;
        tick();

        // frozen vector, withdraw on ie drop, reissue
        irq_in = 4'b0001;
        wait_req("s5_v0", 0);
        irq_in = 4'b1001;
        tick();
        tick();
        chk("s5_frozen_req", {31'b0, int_req}, 32'd1);
        chk("s5_frozen_vec", {30'b0, int_vec}, 32'd0);
        ie = 1'b0;
        tick();
        chk("s5_withdrawn", {31'b0, int_req}, 32'd0);
        tick();
        ie = 1'b1;
        wait_req("s5_reissue", 3);
        ack_cycle("s5_ack3", 32'h0000_00b0, 1'b0);
        do_eret();
        wait_req("s5_pend0", 0);
        ack_cycle("s5_ack0", 32'h0000_00b4, 1'b0);
        do_eret();
        irq_in = 4'b0000;
        tick();

        // rising edge coinciding with the acknowledge clear keeps pending
        irq_in = 4'b0100;
        wait_req("s6_v2", 2);
        irq_in = 4'b0000;
        tick();
        irq_in = 4'b0100;
        ack_cycle("s6_ack", 32'h0000_00c0, 1'b0);
        tick();
        chk("s6_in_service", {31'b0, int_req}, 32'd0);
        do_eret();
        wait_req("s6_again", 2);
        ack_cycle("s6_ack2", 32'h0000_00c4, 1'b0);
        do_eret();
        irq_in = 4'b0000;
        tick();

        // reset during SAVE, then a source held high through release
        irq_in = 4'b0010;
        wait_req("s7_v1", 1);
        int_ack = 1'b1;
        pc_next = 32'h0000_00d0;
        tick();
        chk("s7_save", {31'b0, cp0_we}, 32'd1);
        #2;
        in_RSTn = 1'b0;
        #1;
        chk("s7_abort_we", {31'b0, cp0_we}, 32'd0);
        chk("s7_abort_W", cp0_W, 32'd0);
        chk("s7_abort_rW", {30'b0, cp0_rW}, 32'd0);
        chk("s7_abort_req", {31'b0, int_req}, 32'd0);
        chk("s7_abort_addr", int_addr, 32'h0000_1000);
        int_ack = 1'b0;
        irq_in = 4'b1000;
        tick();
        tick();
        in_RSTn = 1'b1;
        wait_req("s7_held", 3);

        // eret with nothing in service, then eret together with ack
        ack_cycle("s8_ack3", 32'h0000_00e0, 1'b1);
        do_eret();
        irq_in = 4'b1010;
        wait_req("s8_v1", 1);
        ack_cycle("s8_ack1", 32'h0000_00e4, 1'b0);
        irq_in = 4'b1110;
        wait_req("s8_v2", 2);
        ack_cycle("s8_ack2", 32'h0000_00e8, 1'b1);
        irq_in = 4'b1111;
        repeat (3) tick();
        chk("s8_no0", {31'b0, int_req}, 32'd0);
        do_eret();
        wait_req("s8_v0", 0);
        ack_cycle("s8_ack0", 32'h0000_00ec, 1'b0);
        do_eret();
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
